// File: rtl/pal_cfg_loader.sv
// Serialises configuration words MSB-first onto the PAL config chain (cfg_clk/cfg_data)
// and raises cfg_en once exactly CHAIN_LEN bits have been shifted.
module pal_cfg_loader #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_clk,
  output logic              cfg_data,
  output logic              cfg_en,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BL_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned BI_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BL_W-1:0] BL_INIT = BL_W'(CHAIN_LEN);
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_WORD = 3'd1,
    S_SHIFT_LO  = 3'd2,
    S_SHIFT_HI  = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WORD_W-1:0] r_word;
  logic [BI_W-1:0]   r_bit_in_word;
  logic [BL_W-1:0]   r_bits_left;
  logic              r_cfg_clk;
  logic              r_cfg_data;
  logic              r_cfg_en;
  logic              r_word_ready;
  logic              r_busy;
  logic              r_done;

  logic w_busy_state;
  logic w_last_bit;
  logic w_word_end;
  logic w_cfg_clk_nxt;
  logic w_cfg_en_nxt;
  logic w_word_ready_nxt;
  logic w_busy_nxt;
  logic w_done_nxt;
  logic w_load_cnt;
  logic w_capture;
  logic w_advance;
  logic w_next_bit;
  logic w_abort_clr;

  assign w_busy_state = (r_state == S_WAIT_WORD) || (r_state == S_SHIFT_LO) ||
                        (r_state == S_SHIFT_HI);
  assign w_last_bit   = (r_bits_left == BL_W'(1));
  assign w_word_end   = (r_bit_in_word == BI_LAST);

  // State register
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort beats start whenever a load is in flight
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_WAIT_WORD;
      end
      S_WAIT_WORD: begin
        if (abort)           w_state_nxt = S_IDLE;
        else if (word_valid) w_state_nxt = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        if (abort) w_state_nxt = S_IDLE;
        else       w_state_nxt = S_SHIFT_HI;
      end
      S_SHIFT_HI: begin
        if (abort)           w_state_nxt = S_IDLE;
        else if (w_last_bit) w_state_nxt = S_DONE;
        else if (w_word_end) w_state_nxt = S_WAIT_WORD;
        else                 w_state_nxt = S_SHIFT_LO;
      end
      S_DONE: begin
        if (start) w_state_nxt = S_WAIT_WORD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath controls, decoded from the transition being taken
  always_comb begin
    w_cfg_clk_nxt    = 1'b0;
    w_cfg_en_nxt     = 1'b0;
    w_word_ready_nxt = 1'b0;
    w_busy_nxt       = 1'b0;
    w_done_nxt       = 1'b0;
    w_load_cnt       = 1'b0;
    w_capture        = 1'b0;
    w_advance        = 1'b0;
    w_next_bit       = 1'b0;
    w_abort_clr      = 1'b0;

    case (w_state_nxt)
      S_WAIT_WORD: begin
        w_word_ready_nxt = 1'b1;
        w_busy_nxt       = 1'b1;
      end
      S_SHIFT_LO: w_busy_nxt = 1'b1;
      S_SHIFT_HI: begin
        w_cfg_clk_nxt = 1'b1;
        w_busy_nxt    = 1'b1;
      end
      S_DONE: begin
        w_cfg_en_nxt = 1'b1;
        w_done_nxt   = 1'b1;
      end
      default: ;
    endcase

    w_load_cnt  = ((r_state == S_IDLE) || (r_state == S_DONE)) && (w_state_nxt == S_WAIT_WORD);
    w_capture   = (r_state == S_WAIT_WORD) && (w_state_nxt == S_SHIFT_LO);
    w_advance   = (r_state == S_SHIFT_HI) && (w_state_nxt != S_IDLE);
    w_next_bit  = (r_state == S_SHIFT_HI) && (w_state_nxt == S_SHIFT_LO);
    w_abort_clr = w_busy_state && (w_state_nxt == S_IDLE);
  end

  // Registered outputs and shift datapath; cfg_data only moves while cfg_clk is low
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_word        <= '0;
      r_bit_in_word <= '0;
      r_bits_left   <= '0;
      r_cfg_clk     <= 1'b0;
      r_cfg_data    <= 1'b0;
      r_cfg_en      <= 1'b0;
      r_word_ready  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_cfg_clk    <= w_cfg_clk_nxt;
      r_cfg_en     <= w_cfg_en_nxt;
      r_word_ready <= w_word_ready_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;

      if (w_load_cnt) begin
        r_bits_left <= BL_INIT;
      end

      if (w_capture) begin
        r_word        <= word_data << 1;
        r_cfg_data    <= word_data[WORD_W-1];
        r_bit_in_word <= '0;
      end else if (w_advance) begin
        r_bits_left   <= r_bits_left - BL_W'(1);
        r_bit_in_word <= w_word_end ? '0 : r_bit_in_word + BI_W'(1);
        if (w_next_bit) begin
          r_cfg_data <= r_word[WORD_W-1];
          r_word     <= r_word << 1;
        end
      end else if (w_abort_clr) begin
        r_cfg_data <= 1'b0;
      end
    end
  end

  assign word_ready = r_word_ready;
  assign cfg_clk    = r_cfg_clk;
  assign cfg_data   = r_cfg_data;
  assign cfg_en     = r_cfg_en;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Randomised bench for pal_cfg_loader: a chain-side monitor records the bit seen at every
// cfg_clk rise and is compared with the expected prefix of the fed words.
module tb_pal_cfg_loader;

  localparam int unsigned CL = 20;
  localparam int unsigned WW = 8;
  localparam int unsigned NW = (CL + WW - 1) / WW;

  logic          clk = 1'b0;
  logic          res_n;
  logic          start;
  logic          abort;
  logic [WW-1:0] word_data;
  logic          word_valid;
  logic          word_ready;
  logic          cfg_clk;
  logic          cfg_data;
  logic          cfg_en;
  logic          busy;
  logic          done;

  pal_cfg_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .clk        (clk),
    .res_n      (res_n),
    .start      (start),
    .abort      (abort),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .cfg_clk    (cfg_clk),
    .cfg_data   (cfg_data),
    .cfg_en     (cfg_en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  // Chain-side view: bit captured on each cfg_clk rise, and data must not move with the rise
  bit   cap_q[$];
  logic prev_clk  = 1'b0;
  logic prev_data = 1'b0;
  int   stab_viol = 0;
  always @(negedge clk) begin
    if (cfg_clk && !prev_clk) begin
      cap_q.push_back(cfg_data);
      if (cfg_data !== prev_data) stab_viol++;
    end
    prev_clk  = cfg_clk;
    prev_data = cfg_data;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (word_ready) ok = 1'b1;
      else            tick();
    end
  endtask

  // One full load: random words, random valid gaps, optional ignored start mid-load
  task automatic do_load(input int max_gap, input bit restart_mid);
    logic [WW-1:0] words [NW];
    bit            exp_q[$];
    logic [63:0]   exp_v;
    logic [63:0]   got_v;
    int            gaps_sum;
    int            t_acc;
    int            gap;
    logic          gap_clk;
    bit            ok;
    bit            seen_done;

    gaps_sum = 0;
    t_acc    = 0;
    gap_clk  = 1'b0;
    cap_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_en_low", {63'd0, cfg_en}, 64'd0);
    chk("start_busy", {63'd0, busy}, 64'd1);

    for (int w = 0; w < NW; w++) begin
      wait_ready(ok);
      if (!ok) chk("ready_timeout", 64'd0, 64'd1);
      gap = (w == 0) ? 0 : int'($urandom_range(max_gap, 0));
      for (int g = 0; g < gap; g++) begin
        gap_clk = gap_clk | cfg_clk;
        tick();
      end
      words[w]   = WW'($urandom);
      word_data  = words[w];
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      word_data  = WW'($urandom);
      if (w == 0) t_acc = cyc;
      else        gaps_sum += gap;
      if (restart_mid && w == 1) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end

    seen_done = 1'b0;
    for (int i = 0; i < 200 && !seen_done; i++) begin
      if (done) seen_done = 1'b1;
      else      tick();
    end
    chk("done_seen", {63'd0, seen_done}, 64'd1);
    chk("latency", 64'(cyc - t_acc), 64'(2 * CL + (NW - 1) + gaps_sum));
    chk("gap_no_clk", {63'd0, gap_clk}, 64'd0);

    for (int w = 0; w < NW; w++)
      for (int b = WW - 1; b >= 0; b--)
        if (exp_q.size() < CL) exp_q.push_back(words[w][b]);
    exp_v = '0;
    got_v = '0;
    foreach (exp_q[i]) exp_v = {exp_v[62:0], exp_q[i]};
    foreach (cap_q[i]) got_v = {got_v[62:0], cap_q[i]};
    chk("rise_count", 64'(cap_q.size()), 64'(CL));
    chk("bits", got_v, exp_v);
    chk("done_state", {60'd0, cfg_en, word_ready, busy, cfg_clk}, {60'd0, 4'b1000});

    // DONE must ignore both offered words and abort
    word_valid = 1'b1;
    abort      = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    word_valid = 1'b0;
    chk("done_hold", {62'd0, done, cfg_en}, 64'd3);
    chk("done_no_rise", 64'(cap_q.size()), 64'(CL));
  endtask

  // Abort after k rises of the first word, optionally with a coincident start
  task automatic abort_test(input int k, input bit with_start);
    bit ok;
    cap_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_ready(ok);
    if (!ok) chk("abort_ready_timeout", 64'd0, 64'd1);
    word_data  = WW'($urandom);
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    for (int i = 0; i < 100 && cap_q.size() < k; i++) tick();
    abort = 1'b1;
    start = with_start;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_outs", {59'd0, busy, cfg_clk, cfg_en, word_ready, done}, 64'd0);
    word_valid = 1'b1;
    repeat (4) tick();
    word_valid = 1'b0;
    chk("abort_rises", 64'(cap_q.size()), 64'(k));
    chk("abort_idle", {62'd0, busy, word_ready}, 64'd0);
  endtask

  // Asynchronous reset landing while cfg_clk is high
  task automatic reset_test();
    bit ok;
    int n;
    cap_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_ready(ok);
    word_data  = WW'($urandom);
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    for (int i = 0; i < 100 && !cfg_clk; i++) tick();
    chk("rst_in_hi", {63'd0, cfg_clk}, 64'd1);
    #2 res_n = 1'b0;
    #1;
    chk("rst_async", {58'd0, cfg_clk, cfg_data, cfg_en, word_ready, busy, done}, 64'd0);
    @(negedge clk);
    res_n = 1'b1;
    n = cap_q.size();
    word_data  = WW'($urandom);
    word_valid = 1'b1;
    repeat (6) tick();
    word_valid = 1'b0;
    chk("rst_idle", {61'd0, busy, word_ready, cfg_clk}, 64'd0);
    chk("rst_no_rise", 64'(cap_q.size()), 64'(n));
  endtask

  initial begin
    res_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    word_valid = 1'b0;
    word_data  = '0;
    repeat (2) tick();
    chk("reset_outs", {58'd0, cfg_clk, cfg_data, cfg_en, word_ready, busy, done}, 64'd0);
    @(negedge clk);
    res_n = 1'b1;
    tick();

    do_load(0, 1'b0);
    do_load(5, 1'b0);
    do_load(3, 1'b1);
    abort_test(5, 1'b0);
    do_load(0, 1'b0);
    abort_test(int'($urandom_range(WW - 1, 1)), 1'b1);
    reset_test();
    do_load(2, 1'b0);
    for (int r = 0; r < 3; r++) do_load(int'($urandom_range(4, 0)), 1'($urandom_range(1, 0)));
    chk("data_stable", 64'(stab_viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
